// File: rtl/rx_block_lock.sv
// rtl/rx_block_lock.sv - 64b/66b block synchroniser for the 10GBASE-R receive path
module rx_block_lock #(
  parameter int DATA_WIDTH    = 32,
  parameter int HEADER_WIDTH  = 2,
  parameter int LOCK_COUNT    = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_WAIT     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [HEADER_WIDTH-1:0] i_header,
  input  logic                    i_data_valid,
  input  logic                    i_header_valid,
  output logic                    o_slip,
  output logic                    o_block_lock,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [HEADER_WIDTH-1:0] o_header,
  output logic                    o_data_valid,
  output logic                    o_header_valid,
  output logic [7:0]              o_slip_count
);

  localparam int SH_W = $clog2(LOCK_COUNT + 1);
  localparam int IV_W = $clog2(INVALID_LIMIT + 1);
  localparam int WT_W = $clog2(SLIP_WAIT + 1);
  localparam logic [SH_W-1:0] SH_LAST = SH_W'(LOCK_COUNT - 1);
  localparam logic [IV_W-1:0] IV_LAST = IV_W'(INVALID_LIMIT - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(SLIP_WAIT - 1);

  typedef enum logic {ST_TEST, ST_SLIP_WAIT} state_t;

  state_t          state;
  logic [SH_W-1:0] sh_cnt;
  logic [IV_W-1:0] invld_cnt;
  logic [WT_W-1:0] wait_cnt;
  logic            header_ok;
  logic            window_end;
  logic            slip_now;

  assign header_ok  = (i_header == HEADER_WIDTH'(1)) || (i_header == HEADER_WIDTH'(2));
  assign window_end = (sh_cnt == SH_LAST);
  // An invalid header while unlocked slips immediately; while locked only the limit-th one does.
  assign slip_now   = !header_ok && (!o_block_lock || invld_cnt == IV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_TEST;
      sh_cnt         <= '0;
      invld_cnt      <= '0;
      wait_cnt       <= '0;
      o_slip         <= 1'b0;
      o_block_lock   <= 1'b0;
      o_slip_count   <= '0;
      o_data         <= '0;
      o_header       <= '0;
      o_data_valid   <= 1'b0;
      o_header_valid <= 1'b0;
    end else begin
      o_data         <= i_data;
      o_header       <= i_header;
      o_data_valid   <= i_data_valid;
      o_header_valid <= i_header_valid;
      o_slip         <= 1'b0;
      case (state)
        ST_TEST: begin
          if (i_header_valid) begin
            if (header_ok) begin
              if (window_end) begin
                if (invld_cnt == '0) o_block_lock <= 1'b1;
                sh_cnt    <= '0;
                invld_cnt <= '0;
              end else begin
                sh_cnt <= sh_cnt + 1'b1;
              end
            end else if (slip_now) begin
              o_block_lock <= 1'b0;
              o_slip       <= 1'b1;
              sh_cnt       <= '0;
              invld_cnt    <= '0;
              wait_cnt     <= '0;
              state        <= ST_SLIP_WAIT;
              if (o_slip_count != 8'hff) o_slip_count <= o_slip_count + 1'b1;
            end else if (window_end) begin
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else begin
              sh_cnt    <= sh_cnt + 1'b1;
              invld_cnt <= invld_cnt + 1'b1;
            end
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_cnt == WT_LAST) begin
            wait_cnt  <= '0;
            sh_cnt    <= '0;
            invld_cnt <= '0;
            state     <= ST_TEST;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_TEST;
      endcase
    end
  end

endmodule
